// File: rtl/counter_sequencer.sv
// Four-digit BCD up/down counter driven by a start/stop/clear sequencer.
// Buttons are synchronised and edge-detected; steps are paced by a prescaler.
module counter_sequencer #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        inc,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_clear,
  input  logic        dir,
  output logic [15:0] count,
  output logic [1:0]  state,
  output logic        running,
  output logic        wrap
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

  // Bit order in the button vectors: [0] start, [1] stop, [2] clear.
  logic [2:0] btn;
  logic [2:0] sync1_q, sync2_q, sync3_q;
  logic [2:0] ev;
  logic       start_ev, stop_ev, clear_ev;

  state_e      state_q, state_d;
  logic [15:0] pre_q, pre_d;
  logic [15:0] count_q, count_d;
  logic        running_q, running_d;
  logic        wrap_q, wrap_d;

  logic        step;
  logic [15:0] bcd_next;
  logic        carry;
  logic [3:0]  dig;

  assign btn      = {btn_clear, btn_stop, btn_start};
  assign ev       = sync2_q & ~sync3_q;
  assign start_ev = ev[0];
  assign stop_ev  = ev[1];
  assign clear_ev = ev[2];

  always_ff @(posedge inc or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_ev) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (start_ev) state_d = StRun;
        StRun:   if (stop_ev)  state_d = StPause;
        StPause: if (start_ev) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Prescaler only advances in RUN; PAUSE keeps the partial interval for resume.
  always_comb begin
    pre_d = pre_q;
    step  = 1'b0;
    if (clear_ev || state_q == StIdle) begin
      pre_d = '0;
    end else if (state_q == StRun) begin
      if (pre_q == PreMax) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
  end

  // Ripple BCD increment/decrement; carry out of the top digit marks a wrap.
  always_comb begin
    bcd_next = count_q;
    carry    = 1'b1;
    dig      = '0;
    for (int i = 0; i < 4; i++) begin
      dig = count_q[4*i +: 4];
      if (carry) begin
        if (dir) begin
          if (dig >= 4'd9) begin
            bcd_next[4*i +: 4] = 4'd0;
          end else begin
            bcd_next[4*i +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            bcd_next[4*i +: 4] = 4'd9;
          end else begin
            bcd_next[4*i +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    count_d   = count_q;
    wrap_d    = 1'b0;
    running_d = (state_d == StRun);
    if (clear_ev) begin
      count_d = '0;
    end else if (step) begin
      count_d = bcd_next;
      wrap_d  = carry;
    end
  end

  always_ff @(posedge inc or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pre_q     <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      count_q   <= count_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign count   = count_q;
  assign state   = state_q;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer at PRESCALE=4 with hand-computed expectations.
module tb_counter_sequencer;

  logic        inc;
  logic        reset;
  logic        btn_start, btn_stop, btn_clear;
  logic        dir;
  logic [15:0] count;
  logic [1:0]  state;
  logic        running;
  logic        wrap;

  int n_asserts = 0;
  int n_fail    = 0;

  counter_sequencer #(.PRESCALE(4)) dut (
    .inc       (inc),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_clear (btn_clear),
    .dir       (dir),
    .count     (count),
    .state     (state),
    .running   (running),
    .wrap      (wrap)
  );

  initial begin
    inc = 1'b0;
    forever #5 inc = ~inc;
  end

  // Advance n rising edges, then sit 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge inc);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] c, input logic [1:0] s,
                         input logic r, input logic w);
    chk({tag, "_count"}, 32'(count), 32'(c));
    chk({tag, "_state"}, 32'(state), 32'(s));
    chk({tag, "_running"}, 32'(running), 32'(r));
    chk({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  initial begin
    reset = 1'b0;
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_clear = 1'b0;
    dir = 1'b1;

    #3;
    chk_all("rst_hold", 16'h0000, 2'b00, 1'b0, 1'b0);
    tick(2);
    chk_all("rst_clk", 16'h0000, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    tick(2);

    // Start: running at edge N+2, first step 4 edges later.
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    chk("start_n0", 32'(running), 32'd0);
    tick(1);
    chk("start_n1", 32'(running), 32'd0);
    tick(1);
    chk_all("start_n2", 16'h0000, 2'b01, 1'b1, 1'b0);
    tick(3);
    chk("pre_step", 32'(count), 32'h0000);
    tick(1);
    chk("step1", 32'(count), 32'h0001);
    tick(4);
    chk("step2", 32'(count), 32'h0002);
    tick(4 * 7);
    chk("up_0009", 32'(count), 32'h0009);
    tick(4);
    chk_all("up_0010", 16'h0010, 2'b01, 1'b1, 1'b0);
    tick(4 * 89);
    chk("up_0099", 32'(count), 32'h0099);
    tick(4);
    chk_all("up_0100", 16'h0100, 2'b01, 1'b1, 1'b0);

    // Clear from RUN lands between steps.
    btn_clear = 1'b1;
    tick(1);
    btn_clear = 1'b0;
    tick(1);
    chk("clr_pend", 32'(count), 32'h0100);
    tick(1);
    chk_all("clr_done", 16'h0000, 2'b00, 1'b0, 1'b0);
    tick(6);
    chk_all("idle_hold", 16'h0000, 2'b00, 1'b0, 1'b0);

    // Down from zero wraps to 9999.
    dir = 1'b0;
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    tick(2);
    chk("dn_run", 32'(state), 32'd1);
    tick(3);
    chk_all("dn_pre", 16'h0000, 2'b01, 1'b1, 1'b0);
    tick(1);
    chk_all("dn_wrap", 16'h9999, 2'b01, 1'b1, 1'b1);
    tick(1);
    chk_all("dn_wrap_end", 16'h9999, 2'b01, 1'b1, 1'b0);
    tick(3);
    chk_all("dn_9998", 16'h9998, 2'b01, 1'b1, 1'b0);

    // Up through 9999 to 0000.
    dir = 1'b1;
    tick(4);
    chk_all("up_9999", 16'h9999, 2'b01, 1'b1, 1'b0);
    tick(4);
    chk_all("up_wrap", 16'h0000, 2'b01, 1'b1, 1'b1);
    tick(1);
    chk("up_wrap_end", 32'(wrap), 32'd0);

    // Stop lands on a step edge: the step completes, then PAUSE.
    btn_stop = 1'b1;
    tick(1);
    btn_stop = 1'b0;
    tick(1);
    chk_all("stop_pend", 16'h0000, 2'b01, 1'b1, 1'b0);
    tick(1);
    chk_all("stop_step", 16'h0001, 2'b10, 1'b0, 1'b0);
    tick(20);
    chk_all("pause_hold", 16'h0001, 2'b10, 1'b0, 1'b0);

    // Resume with prescaler held at 0: step 4 edges after re-entering RUN.
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    tick(1);
    chk("res0_pend", 32'(state), 32'd2);
    tick(1);
    chk_all("res0_run", 16'h0001, 2'b01, 1'b1, 1'b0);
    tick(3);
    chk("res0_pre", 32'(count), 32'h0001);
    tick(1);
    chk("res0_step", 32'(count), 32'h0002);

    // Pause with prescaler at 2: resume steps exactly 2 edges after RUN.
    tick(3);
    btn_stop = 1'b1;
    tick(1);
    btn_stop = 1'b0;
    chk("p2_step", 32'(count), 32'h0003);
    tick(2);
    chk_all("p2_pause", 16'h0003, 2'b10, 1'b0, 1'b0);
    tick(20);
    chk_all("p2_hold", 16'h0003, 2'b10, 1'b0, 1'b0);
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    tick(2);
    chk_all("p2_run", 16'h0003, 2'b01, 1'b1, 1'b0);
    tick(1);
    chk("p2_pre", 32'(count), 32'h0003);
    tick(1);
    chk("p2_resume_step", 32'(count), 32'h0004);

    // All three buttons together: clear wins; holding yields nothing more.
    btn_start = 1'b1;
    btn_stop  = 1'b1;
    btn_clear = 1'b1;
    tick(2);
    chk("all_pend", 32'(state), 32'd1);
    tick(1);
    chk_all("all_clear", 16'h0000, 2'b00, 1'b0, 1'b0);
    tick(50);
    chk_all("all_hold", 16'h0000, 2'b00, 1'b0, 1'b0);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_clear = 1'b0;
    tick(4);
    chk("all_release", 32'(state), 32'd0);

    // Run to 0042, then async reset mid-cycle with a stop in flight.
    btn_start = 1'b1;
    tick(1);
    btn_start = 1'b0;
    tick(2);
    tick(4 * 42);
    chk_all("at_0042", 16'h0042, 2'b01, 1'b1, 1'b0);
    btn_stop = 1'b1;
    tick(1);
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 2'b00, 1'b0, 1'b0);
    btn_stop = 1'b0;
    #1;
    reset = 1'b1;
    tick(8);
    chk_all("post_rst", 16'h0000, 2'b00, 1'b0, 1'b0);

    // Button held through reset release gives exactly one event.
    reset = 1'b0;
    btn_start = 1'b1;
    #2;
    reset = 1'b1;
    tick(2);
    chk("held_n1", 32'(state), 32'd0);
    tick(1);
    chk_all("held_run", 16'h0000, 2'b01, 1'b1, 1'b0);
    tick(3);
    chk("held_pre", 32'(count), 32'h0000);
    tick(1);
    chk_all("held_step", 16'h0001, 2'b01, 1'b1, 1'b0);
    btn_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: PRESCALE, default 4, clock cycles per count step; legal range 2..65535.
REQ-002 Port: inc  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
REQ-004 Port: btn_start  input  1  asynchronous level; a rising edge requests start or resume.
REQ-005 Port: btn_stop  input  1  asynchronous level; a rising edge requests pause.
REQ-006 Port: btn_clear  input  1  asynchronous level; a rising edge requests clear.
REQ-007 Port: dir  input  1  count direction, 1 = up, 0 = down; sampled on every step.
REQ-008 Port: count  output  16  four packed BCD digits, [15:12] most significant; feeds the 16-bit display count input.
REQ-009 Port: state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE; 11 is never driven.
REQ-010 Port: running  output  1  high exactly when state is RUN.
REQ-011 Port: wrap  output  1  one-cycle pulse on BCD wrap-around.

Function
REQ-012 Each btn_* passes through a 2-flop synchronizer and then a third register.
REQ-013 An event is stage-2 high with stage-3 low.
REQ-014 An input rising before inc edge N takes effect at edge N+2; holding the input high yields exactly one event.
REQ-015 FSM transitions: IDLE --start--> RUN; RUN --stop--> PAUSE; PAUSE --start--> RUN; any state --clear--> IDLE.
REQ-016 start in RUN, stop in IDLE or PAUSE: no effect.
REQ-017 Simultaneous events: clear overrides stop and start; stop overrides start.
REQ-018 Prescaler: counts 0..PRESCALE-1 only in RUN; holds its value in PAUSE; is 0 in IDLE.
REQ-019 A step occurs on the edge where the prescaler equals PRESCALE-1 in RUN; the prescaler returns to 0 on the same edge.
REQ-020 First step occurs PRESCALE edges after the edge that entered RUN from IDLE.
REQ-021 Step with dir=1: BCD increment, each digit 0-9, carry from 9 to the next digit; 9999 -> 0000 with wrap=1 for that cycle.
REQ-022 Step with dir=0: BCD decrement with borrow; 0000 -> 9999 with wrap=1 for that cycle.
REQ-023 count is never a non-BCD digit value.
REQ-024 A clear event sets count=0000 and prescaler=0 at the same edge and suppresses any step and wrap on that edge.
REQ-025 A stop event coinciding with a step edge: the step completes, then the FSM enters PAUSE.
REQ-026 PAUSE holds count unchanged; resuming continues from the held prescaler value.
REQ-027 wrap is registered, asserts for exactly one inc cycle per wrap, and is 0 otherwise.
REQ-028 running and state are registered outputs and change on the same edge as the transition.

Reset
REQ-029 While reset=0: count=0000, state=00 (IDLE), running=0, wrap=0, prescaler=0, all synchronizer and edge registers 0.
REQ-030 Reset asserted mid-operation takes effect without a clock edge and discards any in-flight event.
REQ-031 After reset releases, a button already held high produces one event, since stage 3 starts at 0.

Verification (PRESCALE=4)
REQ-032 Release reset, pulse btn_start, dir=1 -> running=1 at edge N+2; count 0000->0001->0002 every 4 cycles, first step 4 edges after entering RUN.
REQ-033 Preload to 9998 by running, dir=1 -> 9999 then 0000 with wrap=1 for exactly one cycle; count 0009->0010 and 0099->0100 carries are correct.
REQ-034 From IDLE, start with dir=0 -> first step gives 9999 with wrap=1; next step gives 9998.
REQ-035 In RUN at prescaler=2, pulse btn_stop, wait 20 cycles, pulse btn_start -> count frozen during PAUSE; next step exactly 2 cycles after re-entering RUN.
REQ-036 Raise btn_start, btn_stop and btn_clear in the same cycle while in RUN -> state=IDLE, count=0000, wrap=0; holding all buttons high 50 cycles yields no further transitions.
REQ-037 Assert reset=0 between inc edges while in RUN at count 0042 -> count=0000, state=00, running=0 immediately; after release, no action until a new button edge.
